// File: rtl/dmem_arb_pkg.sv
// Shared types and codes for the data-memory arbiter.
package dmem_arb_pkg;

    // Access size codes carried in func3[1:0].
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_align_chk.sv
// Natural-alignment check for one requester's byte address and access size.
module dmem_align_chk
    import dmem_arb_pkg::*;
(
    input  logic [2:0] addr,
    input  logic [2:0] func3,
    output logic       misaligned
);

    // The sign bit of func3 does not affect alignment.
    logic unused_sign;
    assign unused_sign = func3[2];

    // Any nonzero address bit below the access size is misaligned.
    always_comb begin
        misaligned = 1'b0;
        unique case (func3[1:0])
            SZ_B: misaligned = 1'b0;
            SZ_H: misaligned = addr[0];
            SZ_W: misaligned = |addr[1:0];
            SZ_D: misaligned = |addr[2:0];
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (cpu, dma) arbiter for the single-port data memory subsystem.
// Loads keep address and func3 stable until the registered read data returns.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_func3,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [2:0]        dma_func3,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned LAT_W  = $clog2(RD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);

    state_e              state_q;
    owner_e              owner_q;
    logic [LAT_W-1:0]    rd_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    // Last issued access; doubles as the held read address/func3 during RD_WAIT.
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [2:0]          func3_q;

    logic                cpu_mis, dma_mis;
    logic                idle, cpu_win, dma_win;
    logic                win_we, win_mis;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [2:0]          win_func3;
    logic                issue, store, load, rd_done;

    dmem_align_chk u_cpu_chk (
        .addr       (cpu_addr[2:0]),
        .func3      (cpu_func3),
        .misaligned (cpu_mis)
    );

    dmem_align_chk u_dma_chk (
        .addr       (dma_addr[2:0]),
        .func3      (dma_func3),
        .misaligned (dma_mis)
    );

    // Winner selection: dma only beats a concurrent cpu request once starved.
    always_comb begin
        idle    = (state_q == IDLE) && !rst;
        dma_win = idle && dma_req && (!cpu_req || (wait_cnt_q >= WAIT_MAX));
        cpu_win = idle && cpu_req && !dma_win;
        if (dma_win) begin
            win_we    = dma_we;
            win_mis   = dma_mis;
            win_addr  = dma_addr;
            win_data  = dma_wdata;
            win_func3 = dma_func3;
        end else begin
            win_we    = cpu_we;
            win_mis   = cpu_mis;
            win_addr  = cpu_addr;
            win_data  = cpu_wdata;
            win_func3 = cpu_func3;
        end
        issue   = (cpu_win || dma_win) && !win_mis;
        store   = issue && win_we;
        load    = issue && !win_we;
        rd_done = (state_q == RD_WAIT) && (rd_cnt_q == LAT_ONE);
    end

    assign cpu_gnt    = cpu_win;
    assign dma_gnt    = dma_win;
    assign cpu_err    = cpu_win && cpu_mis;
    assign dma_err    = dma_win && dma_mis;
    assign cpu_rvalid = rd_done && (owner_q == OWN_CPU);
    assign dma_rvalid = rd_done && (owner_q == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

    assign mem_we    = store;
    assign mem_re    = load || (state_q == RD_WAIT);
    assign mem_addr  = issue ? win_addr : addr_q;
    assign mem_data  = store ? win_data : data_q;
    assign mem_func3 = issue ? win_func3 : func3_q;

    // Read FSM, held access fields and dma starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_CPU;
            rd_cnt_q   <= '0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            func3_q    <= '0;
        end else begin
            if (issue) begin
                addr_q  <= win_addr;
                func3_q <= win_func3;
            end
            if (store) begin
                data_q <= win_data;
            end
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q  <= RD_WAIT;
                        rd_cnt_q <= LAT_INIT;
                        owner_q  <= dma_win ? OWN_DMA : OWN_CPU;
                    end
                end
                RD_WAIT: begin
                    rd_cnt_q <= rd_cnt_q - LAT_ONE;
                    if (rd_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (dma_req && !dma_win) begin
                if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_q <= wait_cnt_q + WAIT_ONE;
                end
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver runs a cycle-level reference
// model and queues one expected output record per cycle; the monitor checks.
module tb_dmem_arbiter;

    localparam int unsigned RD_LAT   = 1;
    localparam int unsigned MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [63:0] cpu_addr = '0, cpu_wdata = '0;
    logic [2:0]  cpu_func3 = '0;
    logic        cpu_gnt, cpu_rvalid, cpu_err;
    logic [63:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [63:0] dma_addr = '0, dma_wdata = '0;
    logic [2:0]  dma_func3 = '0;
    logic        dma_gnt, dma_rvalid, dma_err;
    logic [63:0] dma_rdata;
    logic        mem_we, mem_re;
    logic [63:0] mem_addr, mem_data;
    logic [2:0]  mem_func3;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (64),
        .DATA_W   (64),
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_func3  (cpu_func3),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_func3  (dma_func3),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_err    (dma_err),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_func3  (mem_func3),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic        chk;
        logic        cpu_gnt, cpu_err, dma_gnt, dma_err;
        logic        mem_we, mem_re, cpu_rvalid, dma_rvalid;
        logic [63:0] cpu_rdata, dma_rdata, mem_addr, mem_data;
        logic [2:0]  mem_func3;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    bit   running = 1'b1;
    bit   rst_cmd = 1'b1;

    // Requester intents (copied to the pins at the start of each cycle).
    bit          c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [63:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
    logic [2:0]  c_f3 = '0, d_f3 = '0;

    // Reference model state.
    bit          m_cg, m_dg, m_own_dma;
    int          m_rd_left = 0, m_wait = 0;
    logic [63:0] m_la = '0, m_ld = '0;
    logic [2:0]  m_lf = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cycle, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s cyc=%0d got=timeout exp=grant", name, cycle);
    endtask

    task automatic model_reset();
        m_rd_left = 0;
        m_wait    = 0;
        m_la      = '0;
        m_ld      = '0;
        m_lf      = '0;
    endtask

    // One clock cycle: drive pins, predict outputs, queue the prediction.
    task automatic step();
        exp_t        e;
        bit          we, mis;
        logic [63:0] a, d;
        logic [2:0]  f;
        @(posedge clk);
        #1;
        cycle++;
        rst       = rst_cmd;
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        cpu_func3 = c_f3;
        dma_req   = d_req;
        dma_we    = d_we;
        dma_addr  = d_addr;
        dma_wdata = d_wdata;
        dma_func3 = d_f3;
        mem_rdata = {$urandom, $urandom};
        e     = '0;
        e.chk = 1'b1;
        m_cg  = 1'b0;
        m_dg  = 1'b0;
        if (rst_cmd) begin
            model_reset();
        end else begin
            if (m_rd_left > 0) begin
                e.mem_re = 1'b1;
                if (m_rd_left == 1) begin
                    if (m_own_dma) begin
                        e.dma_rvalid = 1'b1;
                        e.dma_rdata  = mem_rdata;
                    end else begin
                        e.cpu_rvalid = 1'b1;
                        e.cpu_rdata  = mem_rdata;
                    end
                end
                m_rd_left--;
            end else begin
                if (d_req && (!c_req || m_wait >= MAX_WAIT)) m_dg = 1'b1;
                else if (c_req) m_cg = 1'b1;
                if (m_cg || m_dg) begin
                    we  = m_dg ? d_we : c_we;
                    a   = m_dg ? d_addr : c_addr;
                    d   = m_dg ? d_wdata : c_wdata;
                    f   = m_dg ? d_f3 : c_f3;
                    mis = (a % (64'd1 << f[1:0])) != 64'd0;
                    e.cpu_gnt = m_cg;
                    e.dma_gnt = m_dg;
                    if (mis) begin
                        e.cpu_err = m_cg;
                        e.dma_err = m_dg;
                    end else if (we) begin
                        e.mem_we = 1'b1;
                        m_la = a;
                        m_ld = d;
                        m_lf = f;
                    end else begin
                        e.mem_re  = 1'b1;
                        m_la      = a;
                        m_lf      = f;
                        m_rd_left = RD_LAT;
                        m_own_dma = m_dg;
                    end
                end
            end
            if (d_req && !m_dg) m_wait = (m_wait >= MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            else m_wait = 0;
        end
        e.mem_addr  = m_la;
        e.mem_data  = m_ld;
        e.mem_func3 = m_lf;
        sb.push_back(e);
        if (m_cg) c_req = 1'b0;
        if (m_dg) d_req = 1'b0;
    endtask

    task automatic cpu_set(input bit we, input logic [63:0] a, input logic [63:0] d,
                           input logic [2:0] f);
        c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d; c_f3 = f;
    endtask

    task automatic dma_set(input bit we, input logic [63:0] a, input logic [63:0] d,
                           input logic [2:0] f);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = d; d_f3 = f;
    endtask

    task automatic wait_cpu_gnt(input string name);
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_cg) return;
        end
        expire(name);
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
        return a;
    endfunction

    // Random requesters: fields stay put while pending, occasional drop.
    task automatic gen();
        if (!c_req) begin
            if ($urandom_range(0, 99) < 60)
                cpu_set(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
                        3'($urandom_range(0, 7)));
        end else if ($urandom_range(0, 99) < 4) begin
            c_req = 1'b0;
        end
        if (!d_req) begin
            if ($urandom_range(0, 99) < 35)
                dma_set(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
                        3'($urandom_range(0, 7)));
        end else if ($urandom_range(0, 99) < 4) begin
            d_req = 1'b0;
        end
    endtask

    // Monitor: pop one expectation per cycle and compare at the falling edge.
    initial begin
        exp_t e;
        while (running) begin
            @(negedge clk);
            if (!running) break;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty cyc=%0d got=empty exp=record", cycle);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    chk("gnt_err", 64'({cpu_gnt, cpu_err, dma_gnt, dma_err}),
                        64'({e.cpu_gnt, e.cpu_err, e.dma_gnt, e.dma_err}));
                    chk("mem_ctl", 64'({mem_we, mem_re}), 64'({e.mem_we, e.mem_re}));
                    chk("rvalid", 64'({cpu_rvalid, dma_rvalid}),
                        64'({e.cpu_rvalid, e.dma_rvalid}));
                    chk("cpu_rdata", cpu_rdata, e.cpu_rdata);
                    chk("dma_rdata", dma_rdata, e.dma_rdata);
                    chk("mem_addr", mem_addr, e.mem_addr);
                    chk("mem_data", mem_data, e.mem_data);
                    chk("mem_func3", 64'(mem_func3), 64'(e.mem_func3));
                end
            end
        end
    end

    initial begin
        exp_t skip;
        // Reset state.
        rst_cmd = 1'b1;
        repeat (3) step();
        rst_cmd = 1'b0;
        step();

        // Aligned dword load at 0x10.
        cpu_set(1'b0, 64'h10, 64'h0, 3'd3);
        repeat (4) step();

        // Back-to-back stores.
        cpu_set(1'b1, 64'h00, 64'h1111, 3'd3);
        step();
        cpu_set(1'b1, 64'h08, 64'h2222, 3'd3);
        step();
        cpu_set(1'b1, 64'h10, 64'h3333, 3'd3);
        step();
        step();

        // Misaligned word load.
        cpu_set(1'b0, 64'h06, 64'h0, 3'd2);
        step();
        step();

        // dma starvation behind continuous cpu stores.
        dma_set(1'b1, 64'h100, 64'hD0D0, 3'd3);
        for (int i = 0; i < 14; i++) begin
            if (!c_req) cpu_set(1'b1, 64'(i * 8), 64'(i), 3'd3);
            step();
        end
        c_req = 1'b0;
        step();

        // dma load in flight while a cpu load waits.
        dma_set(1'b0, 64'h200, 64'h0, 3'd3);
        step();
        cpu_set(1'b0, 64'h208, 64'h0, 3'd3);
        wait_cpu_gnt("cpu_after_dma");
        repeat (3) step();

        // Asynchronous reset in the middle of a read.
        cpu_set(1'b0, 64'h40, 64'h0, 3'd3);
        wait_cpu_gnt("rst_ld");
        @(posedge clk);
        #1;
        cycle++;
        cpu_req = c_req;
        dma_req = d_req;
        skip = '0;
        sb.push_back(skip);
        chk("pre_rst_re", 64'(mem_re), 64'd1);
        chk("pre_rst_rv", 64'(cpu_rvalid), 64'd1);
        rst_cmd = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_ctl", 64'({cpu_gnt, cpu_err, dma_gnt, dma_err, mem_we, mem_re,
                            cpu_rvalid, dma_rvalid}), 64'd0);
        chk("rst_rdata", cpu_rdata, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_data", mem_data, 64'd0);
        model_reset();
        repeat (2) step();
        rst_cmd = 1'b0;
        step();
        cpu_set(1'b0, 64'h48, 64'h0, 3'd3);
        wait_cpu_gnt("post_rst_ld");
        repeat (2) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            gen();
            step();
        end
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (3) step();

        @(negedge clk);
        #1;
        running = 1'b0;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester controller for the single-port data memory subsystem (store unit, synchronous BRAM, load unit). It shares the port between the pipeline MEM stage (cpu) and a loader/DMA port (dma), and rejects misaligned accesses. It holds read address and func3 stable until data returns, because load-side extraction uses them combinationally with the registered BRAM output.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
RD_LAT, 1, BRAM read latency in cycles (>=1)
MAX_WAIT, 8, cycles dma may wait before it takes priority over cpu

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cpu_req  in  1  cpu access request
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  store data
cpu_func3  in  3  RISC-V size/sign code
cpu_gnt  out  1  request accepted this cycle
cpu_rvalid  out  1  load data valid
cpu_rdata  out  DATA_W  load data
cpu_err  out  1  misaligned request rejected
dma_req, dma_we, dma_addr, dma_wdata, dma_func3  in  same widths as cpu_*  dma request fields
dma_gnt, dma_rvalid, dma_rdata, dma_err  out  same widths as cpu_*  dma response fields
mem_we  out  1  store enable to memory subsystem
mem_re  out  1  load enable to memory subsystem
mem_addr  out  ADDR_W  address to memory subsystem
mem_data  out  DATA_W  store data to memory subsystem
mem_func3  out  3  func3 to memory subsystem
mem_rdata  in  DATA_W  extracted load data from memory subsystem

Behaviour:
- Reset: state IDLE, wait_cnt=0. All gnt/rvalid/err/mem_we/mem_re outputs are 0; rdata, mem_addr, mem_data and mem_func3 are 0.
- Requester rule: fields stay stable while req=1 until gnt. Dropping req before gnt is legal.
- FSM states: IDLE, RD_WAIT.
- IDLE winner selection:
  - dma wins if dma_req and (!cpu_req or wait_cnt>=MAX_WAIT).
  - Otherwise cpu wins if cpu_req.
  - The winner's gnt is driven combinationally in the same cycle.
- Alignment check uses size=func3[1:0] (0 byte, 1 half, 2 word, 3 dword). A request is misaligned if addr[size-1:0]!=0.
  - Misaligned: gnt=1 and err=1 for one cycle. No mem_we/mem_re. Stay IDLE.
- Aligned store: gnt=1, mem_we=1 for exactly one cycle with the winner's fields. Stay IDLE. Back-to-back stores are allowed every cycle.
- Aligned load at cycle T:
  - gnt=1 and mem_re=1. Latch addr, func3 and owner. Go to RD_WAIT with cnt=RD_LAT.
- RD_WAIT:
  - mem_re, mem_addr and mem_func3 are driven from the latch. cnt decrements each cycle.
  - At cycle T+RD_LAT: owner's rvalid=1 and rdata=mem_rdata for one cycle. Return to IDLE.
  - The earliest next grant is T+RD_LAT+1.
  - No gnt is issued while in RD_WAIT.
- rdata is combinational from mem_rdata while rvalid=1 and 0 otherwise.
- Starvation counter wait_cnt:
  - Saturating; width clog2(MAX_WAIT+1).
  - Increments each cycle that dma_req=1 and dma_gnt=0.
  - Clears on dma_gnt or when dma_req=0.
- Simultaneous cpu_req and dma_req with wait_cnt<MAX_WAIT: cpu wins.
- Async reset mid-read: FSM aborts immediately and no rvalid is emitted. The requester must reissue.
- When idle with no winner: mem_we=mem_re=0; address and data outputs hold their last value.

Decomposition:
- Package dmem_arb_pkg holds:
  - size codes (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3)
  - state enum (IDLE, RD_WAIT)
  - owner encoding (OWN_CPU, OWN_DMA)
- Sub-module dmem_align_chk: combinational; inputs addr[2:0] and func3; output misaligned. It is instantiated once per requester.

Test Plan:
- cpu load addr=0x10, func3=3 (RD_LAT=1) -> cpu_gnt and mem_re at T; cpu_rvalid at T+1 with rdata=mem_rdata; mem_addr=0x10 held through T+1; next grant no earlier than T+2.
- cpu stores to 0x00, 0x08, 0x10 on consecutive cycles -> three single-cycle mem_we pulses; cpu_gnt high three cycles; no rvalid.
- cpu load func3=2 at addr=0x06 -> cpu_gnt=1 and cpu_err=1 same cycle; mem_re=0; FSM stays IDLE.
- cpu_req held high continuously with stores, dma_req high, MAX_WAIT=8 -> dma_gnt on the 9th cycle of waiting; wait_cnt returns to 0; cpu granted next cycle.
- dma load granted while cpu load is pending -> cpu_gnt=0 until dma_rvalid cycle+1; then cpu granted and its rvalid routed only to cpu.
- rst asserted during RD_WAIT -> outputs 0 asynchronously; no rvalid after release; a fresh load completes normally.
